led_pattern_gen: RTL and testbench

//  Parametrised LED driver that generalises the free-running blink counter. It runs on the board

---
 rtl/led_pattern_pkg.sv | 16 +
 rtl/led_tick_prescaler.sv | 37 +++
 rtl/led_pattern_gen.sv | 138 +++++++++++++
 tb/tb_led_pattern_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator family.
//   MODE_*      : encodings of the 2-bit mode selector
//   clog2_min1  : counter/index width helper that never returns 0, so a
//                 one-LED or divide-by-2 build still gets a 1-bit register
package led_pattern_pkg;

  localparam logic [1:0] MODE_COUNT   = 2'd0;
  localparam logic [1:0] MODE_SCAN    = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;
  localparam logic [1:0] MODE_STATIC  = 2'd3;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Step-tick prescaler: counts 0..TICK_DIV-1 on clk25 and wraps.
// Ports:
//   clk25  in  board clock, rising edge
//   rst_   in  synchronous active-low reset (counter -> 0)
//   clear  in  restart the count at 0; suppresses the strobe this cycle
//   tick   out one-cycle strobe while the count reads TICK_DIV-1. This is
//              combinational from the count so the user can register its
//              own tick output on the same edge that it advances state.
module led_tick_prescaler
  import led_pattern_pkg::*;
#(
  parameter int TICK_DIV = 2097152
) (
  input  logic clk25,
  input  logic rst_,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W   = clog2_min1(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk25) begin
    if (!rst_) begin
      cnt <= '0;
    end else if (clear || (cnt == CNT_MAX)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = rst_ && !clear && (cnt == CNT_MAX);

endmodule

// File: rtl/led_pattern_gen.sv
// Parametrised LED driver: binary count, bounce scan, PWM breathe or static
// pattern, stepped by a prescaled tick derived from the board clock.
// Ports:
//   clk25       in   board clock, 25 MHz
//   rst_        in   synchronous active-low reset
//   mode        in   0=COUNT 1=SCAN 2=BREATHE 3=STATIC, sampled every cycle
//   static_val  in   pattern shown in STATIC mode
//   leds        out  registered LED drive, 1 = on
//   tick        out  registered one-cycle pulse per step tick
// A change of mode restarts the prescaler and all pattern state, so the
// new pattern starts from its origin and takes a full TICK_DIV to step.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int TICK_DIV = 2097152,
  parameter int PWM_BITS = 8
) (
  input  logic                clk25,
  input  logic                rst_,
  input  logic [1:0]          mode,
  input  logic [NUM_LEDS-1:0] static_val,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int                  POS_W    = clog2_min1(NUM_LEDS);
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [1:0]          mode_q;
  logic                mode_chg;
  logic                step_stb;
  logic [NUM_LEDS-1:0] step;
  logic [POS_W-1:0]    pos;
  logic                dir_down;   // shared by SCAN and BREATHE; only one runs
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] leds_d;

  assign mode_chg = (mode != mode_q);

  led_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk25 (clk25),
    .rst_  (rst_),
    .clear (mode_chg),
    .tick  (step_stb)
  );

  always_ff @(posedge clk25) begin
    if (!rst_) begin
      mode_q   <= MODE_COUNT;
      step     <= '0;
      pos      <= '0;
      dir_down <= 1'b0;
      duty     <= '0;
      pwm_cnt  <= '0;
      tick     <= 1'b0;
      leds     <= '0;
    end else begin
      mode_q  <= mode;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      tick    <= step_stb;
      leds    <= leds_d;
      if (mode_chg) begin
        step     <= '0;
        pos      <= '0;
        dir_down <= 1'b0;
        duty     <= '0;
      end else if (step_stb) begin
        case (mode_q)
          MODE_COUNT: step <= step + NUM_LEDS'(1);
          MODE_SCAN: begin
            // Turn around on the end LED itself so ends are lit one step only.
            if (NUM_LEDS > 1) begin
              if (!dir_down) begin
                if (pos == POS_LAST) begin
                  dir_down <= 1'b1;
                  pos      <= pos - POS_W'(1);
                end else begin
                  pos <= pos + POS_W'(1);
                end
              end else begin
                if (pos == '0) begin
                  dir_down <= 1'b0;
                  pos      <= pos + POS_W'(1);
                end else begin
                  pos <= pos - POS_W'(1);
                end
              end
            end
          end
          MODE_BREATHE: begin
            if (!dir_down) begin
              if (duty == DUTY_MAX) begin
                dir_down <= 1'b1;
                duty     <= duty - PWM_BITS'(1);
              end else begin
                duty <= duty + PWM_BITS'(1);
              end
            end else begin
              if (duty == '0) begin
                dir_down <= 1'b0;
                duty     <= duty + PWM_BITS'(1);
              end else begin
                duty <= duty - PWM_BITS'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // On a mode change the state registers still hold the old pattern, so the
  // new mode's origin is produced directly rather than from state.
  always_comb begin
    leds_d = '0;
    if (mode_chg) begin
      case (mode)
        MODE_SCAN:   leds_d = NUM_LEDS'(1);
        MODE_STATIC: leds_d = static_val;
        default:     leds_d = '0;
      endcase
    end else begin
      case (mode_q)
        MODE_COUNT:   leds_d = step;
        MODE_SCAN:    leds_d = NUM_LEDS'(1) << pos;
        MODE_BREATHE: leds_d = {NUM_LEDS{pwm_cnt < duty}};
        default:      leds_d = static_val;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with NUM_LEDS=4, TICK_DIV=4, PWM_BITS=3.
// Cycle index k counts clk25 rising edges after reset release (k=1 is the
// first edge with rst_ high); outputs are sampled on the falling edge.
module tb_led_pattern_gen;

  logic       clk25;
  logic       rst_;
  logic [1:0] mode;
  logic [3:0] static_val;
  logic [3:0] leds;
  logic       tick;

  int vectors;
  int miscompares;

  led_pattern_gen #(
    .NUM_LEDS (4),
    .TICK_DIV (4),
    .PWM_BITS (3)
  ) dut (
    .clk25      (clk25),
    .rst_       (rst_),
    .mode       (mode),
    .static_val (static_val),
    .leds       (leds),
    .tick       (tick)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  // COUNT from reset: ticks on k=4,8,..; leds show the step one edge later.
  function automatic logic [3:0] exp_count(input int k);
    return 4'((k - 1) / 4);
  endfunction

  // SCAN / BREATHE from reset: k=1 is the mode-change edge, ticks on k=5,9,..
  function automatic logic [3:0] exp_scan(input int k);
    logic [3:0] tbl [6];
    int j;
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010};
    j = (k < 2) ? 0 : (k - 2) / 4;
    return tbl[j % 6];
  endfunction

  function automatic logic [3:0] exp_breathe(input int k);
    int j, m, d;
    if (k < 2) return 4'b0000;
    j = (k - 2) / 4;
    m = j % 14;
    d = (m <= 7) ? m : 14 - m;
    return (((k - 1) % 8) < d) ? 4'b1111 : 4'b0000;
  endfunction

  function automatic logic exp_tick_from_change(input int k);
    return (k >= 5) && ((k - 1) % 4 == 0);
  endfunction

  task automatic apply_reset(input logic [1:0] m);
    @(negedge clk25);
    mode = m;
    rst_ = 1'b0;
    repeat (3) @(negedge clk25);
    rst_ = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk25);
    mode       = 2'd0;
    static_val = 4'b0000;
    rst_       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk25);
      vectors++;
      if (leds !== 4'b0000 || tick !== 1'b0) begin
        miscompares++;
        $display("FAIL reset cycle %0d: leds=%b tick=%b, expected leds=0000 tick=0", i, leds, tick);
      end
    end
    rst_ = 1'b1;
  endtask

  task automatic test_count();
    // Continues straight from test_reset: mode 0 throughout, no mode change.
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk25);
      vectors++;
      if (tick !== (k % 4 == 0) || leds !== exp_count(k)) begin
        miscompares++;
        $display("FAIL count k=%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                 k, leds, tick, exp_count(k), (k % 4 == 0));
      end
    end
  endtask

  task automatic test_scan();
    apply_reset(2'd1);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk25);
      vectors++;
      if (tick !== exp_tick_from_change(k) || leds !== exp_scan(k)) begin
        miscompares++;
        $display("FAIL scan k=%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                 k, leds, tick, exp_scan(k), exp_tick_from_change(k));
      end
    end
  endtask

  task automatic test_breathe();
    apply_reset(2'd2);
    for (int k = 1; k <= 66; k++) begin
      @(negedge clk25);
      vectors++;
      if (tick !== exp_tick_from_change(k) || leds !== exp_breathe(k)) begin
        miscompares++;
        $display("FAIL breathe k=%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                 k, leds, tick, exp_breathe(k), exp_tick_from_change(k));
      end
    end
  endtask

  task automatic test_static();
    logic [3:0] exp_leds;
    static_val = 4'b1010;
    apply_reset(2'd3);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk25);
      exp_leds = (k <= 6) ? 4'b1010 : 4'b0101;
      vectors++;
      if (tick !== exp_tick_from_change(k) || leds !== exp_leds) begin
        miscompares++;
        $display("FAIL static k=%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                 k, leds, tick, exp_leds, exp_tick_from_change(k));
      end
      if (k == 6) static_val = 4'b0101;
    end
  endtask

  task automatic test_mode_switch();
    logic [3:0] exp_leds;
    apply_reset(2'd0);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk25);
      vectors++;
      if (tick !== (k % 4 == 0) || leds !== exp_count(k)) begin
        miscompares++;
        $display("FAIL switch pre k=%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                 k, leds, tick, exp_count(k), (k % 4 == 0));
      end
    end
    // Step is 5 and the prescaler is about to fire on edge 24.
    mode = 2'd1;
    for (int k = 24; k <= 30; k++) begin
      @(negedge clk25);
      exp_leds = (k <= 28) ? 4'b0001 : 4'b0010;
      vectors++;
      if (tick !== (k == 28) || leds !== exp_leds) begin
        miscompares++;
        $display("FAIL switch post k=%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                 k, leds, tick, exp_leds, (k == 28));
      end
    end
  endtask

  task automatic test_reset_mid_breathe();
    apply_reset(2'd2);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk25);
      vectors++;
      if (leds !== exp_breathe(k)) begin
        miscompares++;
        $display("FAIL midrst pre k=%0d: leds=%b, expected %b", k, leds, exp_breathe(k));
      end
    end
    // leds are on here (duty 4, pwm 2); reset must blank them on the next edge.
    rst_ = 1'b0;
    @(negedge clk25);
    vectors++;
    if (leds !== 4'b0000 || tick !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst edge: leds=%b tick=%b, expected leds=0000 tick=0", leds, tick);
    end
    apply_reset(2'd2);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk25);
      vectors++;
      if (tick !== exp_tick_from_change(k) || leds !== exp_breathe(k)) begin
        miscompares++;
        $display("FAIL midrst post k=%0d: leds=%b tick=%b, expected leds=%b tick=%b",
                 k, leds, tick, exp_breathe(k), exp_tick_from_change(k));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_        = 1'b0;
    mode        = 2'd0;
    static_val  = 4'b0000;
    test_reset();
    test_count();
    test_scan();
    test_breathe();
    test_static();
    test_mode_switch();
    test_reset_mid_breathe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
